pc_sequencer: RTL

Program-counter controller for the PicoMIPS fetch path. Drives the address input of the program memory (default 6-bit, 64 words) and sequences it. It supports linear increment, PC-relative branch, absolute jump, stall, halt/resume, and a wait-for-input handshake. It sits between the decoder/datapath control outputs and the program ROM, and tells the datapath when the fetched instruction is live.

---
 rtl/pc_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter controller for the PicoMIPS fetch path.
//               It provides linear increment, PC-relative branch, absolute
//               jump, stall, halt/resume and a wait-for-input handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int Psize = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             jump_abs,
    input  logic [Psize-1:0] target,
    input  logic             branch_rel,
    input  logic [Psize-1:0] offset,
    input  logic             wait_req,
    input  logic             in_valid,
    output logic             in_ack,
    output logic [Psize-1:0] address,
    output logic             fetch_en,
    output logic [1:0]       state,
    output logic             wrap
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        WAITING = 2'b01,
        HALTED  = 2'b10,
        UNUSED  = 2'b11
    } state_t;

    state_t           r_state;
    logic [Psize-1:0] r_address;
    logic             r_wrap;
    logic [Psize-1:0] w_pc_inc;
    logic             w_pc_at_max;

    // Sequential successor of the PC and the wrap-around condition for it.
    assign w_pc_inc    = r_address + 1'b1;
    assign w_pc_at_max = &r_address;

    // The fetched word only executes while running and not frozen.
    assign fetch_en = (r_state == RUN) && !stall;
    // The input word is consumed only when the sequencer actually advances.
    assign in_ack   = (r_state == WAITING) && in_valid && !stall;

    assign address = r_address;
    assign state   = r_state;
    assign wrap    = r_wrap;

    // PC and mode update; wrap is a one-cycle pulse that clears by default.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_address <= '0;
            r_state   <= RUN;
            r_wrap    <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                RUN: begin
                    if (!stall) begin
                        if (halt) begin
                            r_state <= HALTED;
                        end else if (jump_abs) begin
                            r_address <= target;
                        end else if (branch_rel) begin
                            // Modulo add makes the offset behave as signed.
                            r_address <= r_address + offset;
                        end else if (wait_req) begin
                            r_state <= WAITING;
                        end else begin
                            r_address <= w_pc_inc;
                            r_wrap    <= w_pc_at_max;
                        end
                    end
                end
                WAITING: begin
                    if (!stall && in_valid) begin
                        r_address <= w_pc_inc;
                        r_wrap    <= w_pc_at_max;
                        r_state   <= RUN;
                    end
                end
                HALTED: begin
                    if (!stall && resume) begin
                        r_address <= w_pc_inc;
                        r_wrap    <= w_pc_at_max;
                        r_state   <= RUN;
                    end
                end
                default: begin
                    // Illegal encoding: recover to RUN, keeping the PC.
                    r_state <= RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
